// File: rtl/sentry_dcache_req_queue_pkg.sv
// sentry_dcache_req_queue_pkg: shared request types and lane count.
// Lane count comes from SENTRY_WIDTH (default 4).
`ifndef SENTRY_WIDTH
`define SENTRY_WIDTH 4
`endif
package sentry_dcache_req_queue_pkg;
  localparam int ADDR_W = 32;
  localparam int WIDTH = `SENTRY_WIDTH;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef struct packed {
    logic  store;
    addr_t address;
  } dreq_entry_s;
  function automatic logic same_line(addr_t a, addr_t b, int line_bits);
    return (a >> line_bits) == (b >> line_bits);
  endfunction
endpackage

// File: rtl/sentry_dcache_req_queue_if.sv
// sentry_dcache_req_queue_if: lane request inputs, D-cache head handshake and status.
interface sentry_dcache_req_queue_if #(parameter int DEPTH = 16);
  import sentry_dcache_req_queue_pkg::*;
  logic [WIDTH-1:0]        in_req_valid;
  logic [WIDTH-1:0]        in_req_store;
  addr_t                   in_req_address [WIDTH];
  logic                    req_almost_full;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_store;
  addr_t                   mem_req_address;
  logic [$clog2(DEPTH):0]  occupancy;
  logic                    overflow_err;
  modport slave (
    input  in_req_valid, in_req_store, in_req_address, mem_req_ready,
    output req_almost_full, mem_req_valid, mem_req_store, mem_req_address, occupancy, overflow_err
  );
  modport master (
    output in_req_valid, in_req_store, in_req_address, mem_req_ready,
    input  req_almost_full, mem_req_valid, mem_req_store, mem_req_address, occupancy, overflow_err
  );
endinterface

// File: rtl/sentry_dcache_req_queue_compactor.sv
// sentry_lane_compactor: per-lane packed write offset and push count for surviving lanes.
module sentry_lane_compactor #(
  parameter int WIDTH = 4,
  parameter int OW = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] lane_valid,
  input  logic [WIDTH-1:0] coal_mask,
  output logic [OW-1:0]    offset [WIDTH],
  output logic [OW-1:0]    n_push
);
  logic [OW-1:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc = acc + OW'(lane_valid[i] & ~coal_mask[i]);
    end
    n_push = acc;
  end
endmodule

// File: rtl/sentry_dcache_req_queue.sv
// sentry_dcache_req_queue: packs parallel D-cache requests into a circular buffer, drains one per cycle.
// Optional same-line load coalescing under SENTRY_DREQ_COALESCE_EN.
module sentry_dcache_req_queue
  import sentry_dcache_req_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AF_SLACK = 2 * WIDTH,
  parameter int LINE_BITS = 6
) (
  input logic clk,
  input logic rst,
  sentry_dcache_req_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(WIDTH) + 1;
  if (DEPTH < 2 * WIDTH || (DEPTH & (DEPTH - 1)) != 0 || LINE_BITS >= ADDR_W) begin : g_bad_cfg
    $error("sentry_dcache_req_queue: DEPTH must be a power of 2 >= 2*WIDTH and LINE_BITS < ADDR_W");
  end
  dreq_entry_s   mem_q [DEPTH];
  dreq_entry_s   head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, free, n_acc;
  logic          af_q, af_d, ovf_q, ovf_d, pop;
  logic [WIDTH-1:0] coal, wr_en;
  logic [OW-1:0] offset [WIDTH];
  logic [OW-1:0] n_push;
`ifdef SENTRY_DREQ_COALESCE_EN
  dreq_entry_s last;
  logic        prev_ok;
  addr_t       prev_addr;
  assign last = mem_q[wr_ptr_q - 1'b1];
  // The match candidate walks up the lanes; a store breaks the chain.
  always_comb begin
    coal = '0;
    prev_ok = count_q != '0 && !(pop && count_q == CW'(1)) && !last.store;
    prev_addr = last.address;
    for (int i = 0; i < WIDTH; i++) begin
      if (q.in_req_valid[i]) begin
        coal[i] = !q.in_req_store[i] && prev_ok && same_line(q.in_req_address[i], prev_addr, LINE_BITS);
        prev_ok = !q.in_req_store[i];
        prev_addr = q.in_req_address[i];
      end
    end
  end
`else
  assign coal = '0;
`endif
  sentry_lane_compactor #(.WIDTH(WIDTH), .OW(OW)) u_compactor (
    .lane_valid (q.in_req_valid),
    .coal_mask  (coal),
    .offset     (offset),
    .n_push     (n_push)
  );
  // Free space is measured before this cycle's pop; lanes past it are dropped.
  always_comb begin
    free = CW'(DEPTH) - count_q;
    pop = (count_q != '0) && q.mem_req_ready;
    n_acc = (CW'(n_push) > free) ? free : CW'(n_push);
    for (int i = 0; i < WIDTH; i++)
      wr_en[i] = q.in_req_valid[i] && !coal[i] && (CW'(offset[i]) < free);
    count_d = count_q + n_acc - CW'(pop);
    wr_ptr_d = wr_ptr_q + n_acc[PW-1:0];
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d = ovf_q || (CW'(n_push) > free);
    af_d = (CW'(DEPTH) - count_d) < CW'(AF_SLACK);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      af_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      af_q <= af_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++)
      if (wr_en[i]) mem_q[wr_ptr_q + PW'(offset[i])] <= '{store: q.in_req_store[i], address: q.in_req_address[i]};
  end
  assign head = mem_q[rd_ptr_q];
  assign q.mem_req_valid = count_q != '0;
  assign q.mem_req_store = head.store;
  assign q.mem_req_address = head.address;
  assign q.occupancy = count_q;
  assign q.req_almost_full = af_q;
  assign q.overflow_err = ovf_q;
endmodule

// File: tb/tb_sentry_dcache_req_queue.sv
// tb_sentry_dcache_req_queue: directed vectors plus drain/overflow/reset/coalesce sequences.
module tb_sentry_dcache_req_queue;
  import sentry_dcache_req_queue_pkg::*;
  typedef struct {
    logic [3:0] v, s;
    addr_t      a [4];
    logic       rdy, ev, es, eaf, eov;
    addr_t      ea;
    int         ec;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  sentry_dcache_req_queue_if #(.DEPTH(16)) q ();
  sentry_dcache_req_queue #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .q(q.slave));
  function automatic vec_t mk(logic [3:0] v, s, addr_t a0, a1, a2, a3, logic rdy,
                              logic ev, es, addr_t ea, int ec, logic eaf, eov);
    vec_t t;
    t.v = v; t.s = s; t.a[0] = a0; t.a[1] = a1; t.a[2] = a2; t.a[3] = a3; t.rdy = rdy;
    t.ev = ev; t.es = es; t.ea = ea; t.ec = ec; t.eaf = eaf; t.eov = eov;
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(logic [3:0] v, s, addr_t a0, a1, a2, a3, logic rdy);
    @(negedge clk);
    q.in_req_valid = v;
    q.in_req_store = s;
    q.in_req_address[0] = a0;
    q.in_req_address[1] = a1;
    q.in_req_address[2] = a2;
    q.in_req_address[3] = a3;
    q.mem_req_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic check_state(string tag, logic ev, es, addr_t ea, int ec, logic eaf, eov);
    chk({tag, " valid"}, q.mem_req_valid, ev);
    if (ev) begin
      chk({tag, " store"}, q.mem_req_store, es);
      chk({tag, " addr"}, q.mem_req_address, ea);
    end
    chk({tag, " count"}, q.occupancy, ec);
    chk({tag, " almost_full"}, q.req_almost_full, eaf);
    chk({tag, " overflow"}, q.overflow_err, eov);
  endtask
  // Pops with no pushes; exp holds the head seen after each pop (all loads).
  task automatic drain(string tag, addr_t exp [$], int start, logic eov);
    for (int k = 0; k < start; k++) begin
      int c;
      c = start - 1 - k;
      drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
      check_state($sformatf("%s pop%0d", tag, k), c != 0, 1'b0, (c != 0) ? exp[k] : '0, c, (16 - c) < 8, eov);
    end
  endtask
  vec_t tv [$];
  addr_t exp1 [$];
  addr_t exp2 [$];
  addr_t heads [5];
  int cnts [5];
  initial begin
    tv.push_back(mk(4'b0101, 4'b0100, 'h100, 0, 'h200, 0, 1, 1, 0, 'h100, 2, 0, 0));
    tv.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 1, 'h200, 1, 0, 0));
    tv.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(4'b1111, 4'b0000, 'h1000, 'h1100, 'h1200, 'h1300, 0, 1, 0, 'h1000, 4, 0, 0));
    tv.push_back(mk(4'b1111, 4'b0000, 'h2000, 'h2100, 'h2200, 'h2300, 0, 1, 0, 'h1000, 8, 0, 0));
    tv.push_back(mk(4'b1111, 4'b0000, 'h3000, 'h3100, 'h3200, 'h3300, 0, 1, 0, 'h1000, 12, 1, 0));
    tv.push_back(mk(4'b0011, 4'b0000, 'h4000, 'h4100, 0, 0, 0, 1, 0, 'h1000, 14, 1, 0));
    tv.push_back(mk(4'b1111, 4'b0000, 'h5000, 'h5100, 'h5200, 'h5300, 0, 1, 0, 'h1000, 16, 1, 1));
    exp1 = '{'h1100, 'h1200, 'h1300, 'h2000, 'h2100, 'h2200, 'h2300, 'h3000, 'h3100,
             'h3200, 'h3300, 'h4000, 'h4100, 'h5000, 'h5100};
    exp2 = '{'h7200, 'h7300, 'h8000, 'h8100, 'h8200, 'h8300, 'h9000, 'h9100, 'h9200,
             'h9300, 'hA000, 'hA100, 'hB000, 'hC000};
    heads = '{'h6100, 'h6200, 'h6300, 'h7000, 'h7100};
    cnts = '{11, 14, 15, 15, 15};
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b0);
    check_state("reset", 0, 0, '0, 0, 0, 0);
    rst = 1'b0;
    foreach (tv[i])
      begin
        drive(tv[i].v, tv[i].s, tv[i].a[0], tv[i].a[1], tv[i].a[2], tv[i].a[3], tv[i].rdy);
        check_state($sformatf("vec%0d", i), tv[i].ev, tv[i].es, tv[i].ea, tv[i].ec, tv[i].eaf, tv[i].eov);
      end
    drain("drain1", exp1, 16, 1'b1);
    rst = 1'b1;
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b0);
    check_state("reset2", 0, 0, '0, 0, 0, 0);
    rst = 1'b0;
    drive(4'hf, 4'h0, 'h6000, 'h6100, 'h6200, 'h6300, 1'b0);
    check_state("fill6", 1, 0, 'h6000, 4, 0, 0);
    drive(4'hf, 4'h0, 'h7000, 'h7100, 'h7200, 'h7300, 1'b0);
    check_state("fill7", 1, 0, 'h6000, 8, 0, 0);
    for (int k = 0; k < 5; k++) begin
      addr_t b;
      b = addr_t'('h8000 + k * 'h1000);
      drive(4'hf, 4'h0, b, b + 'h100, b + 'h200, b + 'h300, 1'b1);
      check_state($sformatf("pushpop%0d", k), 1, 0, heads[k], cnts[k], 1, k >= 2);
    end
    drain("drain2", exp2, 15, 1'b1);
    rst = 1'b1;
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    drive(4'hf, 4'h0, 'hD000, 'hD100, 'hD200, 'hD300, 1'b0);
    drive(4'hf, 4'h0, 'hE000, 'hE100, 'hE200, 'hE300, 1'b0);
    drive(4'h3, 4'h0, 'hF000, 'hF100, '0, '0, 1'b0);
    check_state("at10", 1, 0, 'hD000, 10, 1, 0);
    rst = 1'b1;
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
    check_state("reset_mid", 0, 0, '0, 0, 0, 0);
    rst = 1'b0;
    drive(4'hf, 4'b1000, 'h1000, 'h1010, 'h1040, 'h1044, 1'b0);
`ifdef SENTRY_DREQ_COALESCE_EN
    check_state("coal_push", 1, 0, 'h1000, 3, 0, 0);
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
    check_state("coal_pop0", 1, 0, 'h1040, 2, 0, 0);
`else
    check_state("coal_push", 1, 0, 'h1000, 4, 0, 0);
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
    check_state("coal_pop0", 1, 0, 'h1010, 3, 0, 0);
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
    check_state("coal_pop1", 1, 0, 'h1040, 2, 0, 0);
`endif
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
    check_state("coal_store", 1, 1, 'h1044, 1, 0, 0);
    drive(4'h0, 4'h0, '0, '0, '0, '0, 1'b1);
    check_state("coal_empty", 0, 0, '0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
